dmem_arbiter: RTL
=================

# dmem_arbiter

Shares the single-ported, fixed-latency data memory between two requesters: port 0 is the core load/store path, port 1 is the block-copy/debug engine. It accepts one access at a time, holds the command on the memory bus for the memory's full access latency, and returns a one-cycle completion pulse with read data to the owning port. It also produces the stall indication the microcoded controller uses to extend load/store stay cycles while port 0 is waiting.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MEM_LAT, 2, memory access cycles, minimum 1
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- pN_req  in  1  access request, N = 0,1; held until pN_gnt
- pN_we  in  1  1 = write, 0 = read
- pN_addr  in  ADDR_W  byte address, passed through unmodified
- pN_wdata  in  DATA_W  write data
- pN_be  in  DATA_W/8  byte enables
- pN_gnt  out  1  combinational; command accepted this cycle
- pN_done  out  1  registered one-cycle completion pulse, reads and writes
- pN_rdata  out  DATA_W  read data; valid only while pN_done is high for a read
- mem_en, mem_we  out  1  memory enable and write strobe
- mem_addr, mem_wdata, mem_be  out  widths as above  latched command
- mem_rdata  in  DATA_W  memory read data, valid in the last BUSY cycle
- p0_stall  out  1  p0_req & ~p0_gnt, or a port-0 access outstanding and p0_done not yet asserted

## Operation
- FSM states: IDLE and BUSY. A down-counter cnt of width clog2(MEM_LAT) bits tracks the access; owner records the granted port id.
- IDLE: if any pN_req is high, assert the winner's pN_gnt. At the clock edge, latch we, addr, wdata, be, and owner, set cnt = MEM_LAT-1, and go to BUSY. With no request, stay in IDLE.
- BUSY: mem_en = 1, and mem_we = latched we. When cnt = 0, register mem_rdata into the owner's rdata, set the owner's done for the next cycle, and return to IDLE. Otherwise decrement cnt.
- In the cycle done is high the FSM is already IDLE, so a new grant can occur in that same cycle. Back-to-back throughput is one access per MEM_LAT+1 cycles.
- Arbitration (default): fixed priority, port 0 wins. The port that is not granted keeps its req high and sees gnt = 0.
- A req still high in the cycle after gnt is a new request.
- Outputs in IDLE: mem_en = mem_we = 0. mem_addr, mem_wdata and mem_be hold their last latched values.
- Misalignment is not checked. be is forwarded exactly as received.

## Timing
- Reset values: state IDLE, cnt 0, owner 0, all gnt/done 0, rdata 0, mem_en = mem_we = 0, mem_addr/wdata/be 0, round-robin pointer = port 1 (so port 0 wins first).
- Reset asserted mid-access aborts the access. mem_en drops asynchronously and no done is issued.
- Grant in cycle T. BUSY in cycles T+1 through T+MEM_LAT. pN_done and pN_rdata appear in cycle T+MEM_LAT+1.
- With MEM_LAT = 1, BUSY lasts exactly one cycle.
- If both ports request while BUSY, nothing is granted until IDLE is reached. Arbitration is then evaluated in that IDLE cycle.

## Configuration
- DMEM_ARB_RR_EN defined: two-port round robin. A last-grant pointer updates on every grant, and on a tie the port not granted last wins. A lone requester always wins.
- DMEM_ARB_RR_EN undefined: fixed priority to port 0, and no pointer register exists.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum {IDLE, BUSY};
  - the port-id typedef (1 bit);
  - the default MEM_LAT constant;
  - the command struct typedef {we, addr, wdata, be}, parameterised through localparams.
- Sub-module arb_sel2 is the combinational two-way selector with optional pointer state. It takes req[1:0] and last and returns a one-hot grant. It compiles the round-robin path under DMEM_ARB_RR_EN.
- Top level contains the FSM, counter, command/owner registers, rdata registers and stall logic.

## Test plan
- Port-0 read, addr 0x100, mem returns 0xDEADBEEF, MEM_LAT = 2 -> p0_gnt in cycle 0, mem_en high in cycles 1–2, p0_done with p0_rdata 0xDEADBEEF in cycle 3, p0_stall high in cycles 0–2.
- Port-1 write, addr 0x20, wdata 0x12345678, be 4'b0011 -> mem_we high for 2 cycles with the latched values, then p1_done, with p1_rdata ignored.
- Both ports request continuously in fixed-priority mode -> port 0 is granted in every IDLE cycle (0, 3, 6, …) and port 1 is never granted. With DMEM_ARB_RR_EN, grants alternate 0, 1, 0, 1.
- Port 1 requests one cycle after a port-0 grant -> p1_gnt arrives in the port-0 done cycle, and p1_done follows 3 cycles later.
- rstn pulsed low in the second BUSY cycle -> mem_en falls immediately, no done pulse occurs, and after release the FSM is IDLE with all outputs at reset values.
- MEM_LAT = 1 build, back-to-back port-0 reads -> one grant every 2 cycles, done lags gnt by 2 cycles.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    localparam int DMEM_ADDR_W  = 32;
    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_BE_W    = DMEM_DATA_W / 8;
    localparam int DMEM_MEM_LAT = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    typedef logic port_id_t;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
        logic [DMEM_BE_W-1:0]   be;
    } cmd_t;

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_arb_sel2.sv
// ============================================================================
// arb_sel2: combinational two-way selector returning a one-hot grant.
// DMEM_ARB_RR_EN selects round robin against last_i; otherwise port 0 wins.
// Revision: 1.0
// ============================================================================
`default_nettype none

module arb_sel2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  port_id_t   last_i,
    output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
    // On a tie the port that was not granted last goes next.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end
`else
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0]) begin
            gnt_o = 2'b01;
        end else if (req_i[1]) begin
            gnt_o = 2'b10;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter: shares a single-ported fixed-latency data memory between the
// core load/store port (0) and the copy/debug port (1). Macro: DMEM_ARB_RR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    // Command widths come from the package struct; override there together.
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int MEM_LAT = DMEM_MEM_LAT
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                p0_req_i,
    input  logic                p0_we_i,
    input  logic [ADDR_W-1:0]   p0_addr_i,
    input  logic [DATA_W-1:0]   p0_wdata_i,
    input  logic [DATA_W/8-1:0] p0_be_i,
    output logic                p0_gnt_o,
    output logic                p0_done_o,
    output logic [DATA_W-1:0]   p0_rdata_o,
    output logic                p0_stall_o,

    input  logic                p1_req_i,
    input  logic                p1_we_i,
    input  logic [ADDR_W-1:0]   p1_addr_i,
    input  logic [DATA_W-1:0]   p1_wdata_i,
    input  logic [DATA_W/8-1:0] p1_be_i,
    output logic                p1_gnt_o,
    output logic                p1_done_o,
    output logic [DATA_W-1:0]   p1_rdata_o,

    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    port_id_t            owner_q, owner_d;
    cmd_t                cmd_q, cmd_d;
    logic                p0_done_q, p0_done_d;
    logic                p1_done_q, p1_done_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

    logic [1:0]          w_req;
    logic [1:0]          w_gnt;
    port_id_t            w_last;
    cmd_t                w_cmd0, w_cmd1;

    assign w_req  = {p1_req_i, p0_req_i} & {2{state_q == IDLE}};
    assign w_cmd0 = '{we: p0_we_i, addr: p0_addr_i, wdata: p0_wdata_i, be: p0_be_i};
    assign w_cmd1 = '{we: p1_we_i, addr: p1_addr_i, wdata: p1_wdata_i, be: p1_be_i};

    arb_sel2 u_sel (
        .req_i  (w_req),
        .last_i (w_last),
        .gnt_o  (w_gnt)
    );

`ifdef DMEM_ARB_RR_EN
    port_id_t last_q;

    // Reset to port 1 so that port 0 wins the first tie.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else if (|w_gnt) begin
            last_q <= w_gnt[1];
        end
    end

    assign w_last = last_q;
`else
    assign w_last = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_d    = owner_q;
        cmd_d      = cmd_q;
        p0_done_d  = 1'b0;
        p1_done_d  = 1'b0;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        case (state_q)
            IDLE: begin
                if (|w_gnt) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    owner_d = w_gnt[1];
                    cmd_d   = w_gnt[1] ? w_cmd1 : w_cmd0;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        p1_done_d  = 1'b1;
                        p1_rdata_d = mem_rdata_i;
                    end else begin
                        p0_done_d  = 1'b1;
                        p0_rdata_d = mem_rdata_i;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= 1'b0;
            cmd_q      <= '0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_q    <= owner_d;
            cmd_q      <= cmd_d;
            p0_done_q  <= p0_done_d;
            p1_done_q  <= p1_done_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0_gnt_o    = w_gnt[0];
    assign p1_gnt_o    = w_gnt[1];
    assign p0_done_o   = p0_done_q;
    assign p1_done_o   = p1_done_q;
    assign p0_rdata_o  = p0_rdata_q;
    assign p1_rdata_o  = p1_rdata_q;

    assign mem_en_o    = (state_q == BUSY);
    assign mem_we_o    = (state_q == BUSY) & cmd_q.we;
    assign mem_addr_o  = cmd_q.addr;
    assign mem_wdata_o = cmd_q.wdata;
    assign mem_be_o    = cmd_q.be;

    // A granted port-0 request counts as waiting until its done cycle.
    assign p0_stall_o  = p0_req_i | ((state_q == BUSY) & (owner_q == 1'b0));

endmodule

`default_nettype wire
